// File: rtl/clock_sys_pkg.sv
// Shared types and constants for the clock-system display refresh path.
package clock_sys_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // Largest value representable in num_digit decimal digits.
    function automatic int max_bcd_val(input int num_digit);
        int v;
        v = 1;
        for (int i = 0; i < num_digit; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
module rr_arbiter
    import clock_sys_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic              valid
);

    // Scan farthest-first so the nearest requester after ptr is assigned last and wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Time-shares one external binary-to-BCD converter among several clock fields,
// storing each channel's digits in a BCD bank.
module bcd_conv_scheduler
    import clock_sys_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BIN_W     = 7,
    parameter int NUM_DIGIT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             req,
    input  logic [NUM_CH*BIN_W-1:0]       req_bin,
    output logic [NUM_CH-1:0]             ack,
    output logic [BIN_W-1:0]              conv_bin,
    input  logic [NUM_DIGIT*4-1:0]        conv_bcd,
    output logic [NUM_CH*NUM_DIGIT*4-1:0] bcd_out,
    output logic [NUM_CH-1:0]             upd,
    output logic                          busy
);

    localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SLICE_W = NUM_DIGIT * 4;
    localparam int MAX_VAL = max_bcd_val(NUM_DIGIT);

    state_t             state_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [BIN_W-1:0]   bin_q;
    logic [PTR_W-1:0]   ch_q;
    logic [SLICE_W-1:0] bank_reg [NUM_CH];
    logic [BIN_W-1:0]   req_bin_arr [NUM_CH];

    logic [NUM_CH-1:0]  grant;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [SLICE_W-1:0] capture_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slices
            assign req_bin_arr[gi]                   = req_bin[gi*BIN_W +: BIN_W];
            assign bcd_out[gi*SLICE_W +: SLICE_W]    = bank_reg[gi];
        end
    endgenerate

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
            end
        end
    end

    // Values that do not fit the digit count are shown as blanks.
    assign capture_data = (32'(bin_q) > 32'(MAX_VAL)) ? {NUM_DIGIT{BLANK_DIGIT}} : conv_bcd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= PTR_W'(NUM_CH - 1);
            bin_q     <= '0;
            ch_q      <= '0;
            conv_bin  <= '0;
            ack       <= '0;
            upd       <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                bank_reg[i] <= '0;
            end
        end else begin
            ack <= '0;
            upd <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        bin_q     <= req_bin_arr[grant_idx];
                        conv_bin  <= req_bin_arr[grant_idx];
                        ch_q      <= grant_idx;
                        ack       <= grant;
                        busy      <= 1'b1;
                        state_reg <= ISSUE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    // conv_bin already carries bin_q; this cycle lets the converter settle.
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    bank_reg[ch_q] <= capture_data;
                    upd[ch_q]      <= 1'b1;
                    ptr_reg        <= ch_q;
                    state_reg      <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Self-checking bench: directed and random request batches against a transaction-level model.
module tb_bcd_conv_scheduler;

    localparam int NUM_CH    = 4;
    localparam int BIN_W     = 7;
    localparam int NUM_DIGIT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [27:0] req_bin;
    logic [3:0]  ack;
    logic [6:0]  conv_bin;
    logic [7:0]  conv_bcd;
    logic [31:0] bcd_out;
    logic [3:0]  upd;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  bank_m [4];
    int          ptr_m;
    int          vals [4];

    always #5 clk = ~clk;

    // Shared converter living outside the scheduler.
    assign conv_bcd = {4'((conv_bin / 7'd10) % 7'd10), 4'(conv_bin % 7'd10)};

    bcd_conv_scheduler #(
        .NUM_CH    (NUM_CH),
        .BIN_W     (BIN_W),
        .NUM_DIGIT (NUM_DIGIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_bin  (req_bin),
        .ack      (ack),
        .conv_bin (conv_bin),
        .conv_bcd (conv_bcd),
        .bcd_out  (bcd_out),
        .upd      (upd),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bank_vec();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = bank_m[i];
        return v;
    endfunction

    function automatic logic [7:0] exp_bcd(input int v);
        if (v > 99) return 8'hFF;
        return {4'(v / 10), 4'(v - (v / 10) * 10)};
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_vals();
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            t = 32'(vals[i]);
            req_bin[i*7 +: 7] = t[6:0];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) bank_m[i] = 8'h00;
        ptr_m = 3;
    endtask

    task automatic check_idle(input string tag);
        step();
        chk({tag, "_ack"}, 32'(ack), 32'h0);
        chk({tag, "_upd"}, 32'(upd), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_bank"}, bcd_out, bank_vec());
    endtask

    // Raises mask, expects n grants in round-robin order; hold bits keep their req high.
    task automatic run_batch(input logic [3:0] mask, input logic [3:0] hold, input int n);
        int c;
        logic [31:0] exp_ack;
        req = req | mask;
        pack_vals();
        for (int g = 0; g < n; g++) begin
            c = pick(req, ptr_m);
            exp_ack = (c < 0) ? 32'h0 : (32'h1 << c);
            if (c < 0) c = 0;
            step();
            chk("grant_ack", 32'(ack), exp_ack);
            chk("grant_busy", 32'(busy), 32'h1);
            chk("grant_conv_bin", 32'(conv_bin), 32'(vals[c] % 128));
            if (!hold[c]) req[c] = 1'b0;
            step();
            chk("issue_ack", 32'(ack), 32'h0);
            chk("issue_upd", 32'(upd), 32'h0);
            chk("issue_conv_bin", 32'(conv_bin), 32'(vals[c] % 128));
            chk("issue_busy", 32'(busy), 32'h1);
            step();
            bank_m[c] = exp_bcd(vals[c]);
            ptr_m = c;
            chk("capture_upd", 32'(upd), 32'h1 << c);
            chk("capture_ack", 32'(ack), 32'h0);
            chk("capture_bank", bcd_out, bank_vec());
            chk("capture_busy", 32'(busy), 32'h1);
            $display("txn ch%0d val %0d bcd %h bank %h", c, vals[c], bank_m[c], bcd_out);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0;
        step();
        step();
        clear_model();
        chk("rst_bank", bcd_out, 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_conv_bin", 32'(conv_bin), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        req = 4'b0;
        for (int i = 0; i < 4; i++) vals[i] = 0;
        pack_vals();
        clear_model();

        do_reset();
        for (int i = 0; i < 10; i++) begin
            check_idle("idle");
            chk("idle_conv_bin", 32'(conv_bin), 32'h0);
        end

        // Single request on ch1
        vals[1] = 45;
        run_batch(4'b0010, 4'b0000, 1);
        chk("single_ch1", 32'(bcd_out[15:8]), 32'h45);
        check_idle("single_end");

        // Round robin from reset
        do_reset();
        vals[0] = 59; vals[1] = 30; vals[2] = 23; vals[3] = 7;
        run_batch(4'b1111, 4'b0000, 4);
        chk("rr_bank", bcd_out, 32'h07233059);
        check_idle("rr_end");

        // Overflow blanking then largest in-range value
        vals[3] = 100;
        run_batch(4'b1000, 4'b0000, 1);
        chk("ovf_blank", 32'(bcd_out[31:24]), 32'hFF);
        vals[3] = 99;
        run_batch(4'b1000, 4'b0000, 1);
        chk("ovf_99", 32'(bcd_out[31:24]), 32'h99);
        check_idle("ovf_end");

        // Reset during ISSUE discards the conversion
        vals[2] = 12;
        pack_vals();
        req = 4'b0100;
        step();
        chk("midrst_ack", 32'(ack), 32'h4);
        req = 4'b0;
        rst_n = 1'b0;
        step();
        clear_model();
        chk("midrst_ack_clr", 32'(ack), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step();
        chk("midrst_no_upd", 32'(upd), 32'h0);
        chk("midrst_ch2", 32'(bcd_out[23:16]), 32'h0);
        step();
        chk("midrst_no_upd2", 32'(upd), 32'h0);
        vals[0] = 5;
        req = 4'b0101;
        pack_vals();
        step();
        chk("midrst_ch0_first", 32'(ack), 32'h1);
        req = 4'b0100;
        step();
        step();
        bank_m[0] = exp_bcd(vals[0]);
        ptr_m = 0;
        chk("midrst_ch0_upd", 32'(upd), 32'h1);
        run_batch(4'b0100, 4'b0000, 1);
        check_idle("midrst_end");

        // Held request: ch0 re-granted, then ch1 goes ahead of ch0
        vals[0] = 17; vals[1] = 42;
        run_batch(4'b0001, 4'b0001, 2);
        run_batch(4'b0011, 4'b0001, 2);
        req = 4'b0;
        check_idle("hold_end");

        // Random batches
        for (int b = 0; b < 8; b++) begin
            logic [3:0] m;
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) vals[i] = int'($urandom_range(0, 127));
            run_batch(m, 4'b0000, $countones(m));
            check_idle("rand_end");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
